regfile_write_arbiter: RTL and testbench

- Shares the single write port of the CPU register bank among REQ_N requesters, e.g. ALU writeback, load unit and serial-load shift path.
- Picks at most one write per cycle with a round-robin pointer.
- The winning write is registered and driven to the bank as write_enabled plus address and data. The address feeds the register address decoder.
- Each requester receives a one-cycle ack pulse.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/rr_pick.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 57 +++++
 tb/tb_regfile_write_arbiter.sv | 132 +++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: register bank geometry shared by the bank, its address decoder and the write arbiter
package cpu_pkg;
  localparam int CPU_REG_N = 8;
  localparam int CPU_WIDTH = 16;
  localparam int CPU_ADDR_W = $clog2(CPU_REG_N);
  localparam int CPU_REQ_N = 4;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester-side write requests and the arbitrated bank write port
interface regfile_write_arbiter_if import cpu_pkg::*; #(
  parameter int REQ_N = CPU_REQ_N,
  parameter int WIDTH = CPU_WIDTH,
  parameter int REG_N = CPU_REG_N,
  localparam int ADDR_W = $clog2(REG_N),
  localparam int IDX_W = idx_w(REQ_N)
);
  logic [REQ_N-1:0] req;
  logic [REQ_N*ADDR_W-1:0] req_addr;
  logic [REQ_N*WIDTH-1:0] req_data;
  logic stall;
  logic [REQ_N-1:0] ack;
  logic write_enabled;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0] write_data;
  logic [IDX_W-1:0] grant_id;
  modport master (
    output req, req_addr, req_data, stall,
    input ack, write_enabled, write_addr, write_data, grant_id
  );
  modport slave (
    input req, req_addr, req_data, stall,
    output ack, write_enabled, write_addr, write_data, grant_id
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first eligible requester scanning upward from rr_ptr with wrap at REQ_N-1
module rr_pick import cpu_pkg::*; #(
  parameter int REQ_N = CPU_REQ_N,
  localparam int IDX_W = idx_w(REQ_N)
) (
  input logic [REQ_N-1:0] eligible,
  input logic [IDX_W-1:0] rr_ptr,
  output logic found,
  output logic [IDX_W-1:0] winner
);
  logic [IDX_W-1:0] idx;
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = rr_ptr;
    for (int k = 0; k < REQ_N; k++) begin
      if (!found && eligible[idx]) begin
        found = 1'b1;
        winner = idx;
      end
      idx = (idx == IDX_W'(REQ_N - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register bank write port, one registered write per cycle
module regfile_write_arbiter import cpu_pkg::*; #(
  parameter int REQ_N = CPU_REQ_N,
  parameter int WIDTH = CPU_WIDTH,
  parameter int REG_N = CPU_REG_N,
  localparam int ADDR_W = $clog2(REG_N),
  localparam int IDX_W = idx_w(REQ_N)
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, winner;
  logic [REQ_N-1:0] ack_q, ack_d, eligible;
  logic write_enabled_q, write_enabled_d, found, grant;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  // a requester still seeing its ack is masked so a held req is not written twice
  assign eligible = bus.req & ~ack_q;
  rr_pick #(.REQ_N(REQ_N)) u_pick (
    .eligible(eligible),
    .rr_ptr(rr_ptr_q),
    .found(found),
    .winner(winner)
  );
  always_comb begin
    grant = found & ~bus.stall;
    write_enabled_d = grant;
    ack_d = grant ? REQ_N'(1) << winner : '0;
    grant_id_d = grant ? winner : grant_id_q;
    write_addr_d = grant ? bus.req_addr[winner*ADDR_W +: ADDR_W] : write_addr_q;
    write_data_d = grant ? bus.req_data[winner*WIDTH +: WIDTH] : write_data_q;
    rr_ptr_d = grant ? ((winner == IDX_W'(REQ_N - 1)) ? '0 : winner + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      ack_q <= '0;
      write_enabled_q <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      grant_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ack_q <= ack_d;
      write_enabled_q <= write_enabled_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      grant_id_q <= grant_id_d;
    end
  end
  assign bus.ack = ack_q;
  assign bus.write_enabled = write_enabled_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table plus hand sequences for reset, stall and wrap corners
module tb_regfile_write_arbiter;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_write_arbiter_if #(.REQ_N(4)) b4();
  regfile_write_arbiter_if #(.REQ_N(3)) b3();
  regfile_write_arbiter #(.REQ_N(4)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  regfile_write_arbiter #(.REQ_N(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));
  typedef struct {
    logic [3:0] req;
    logic stall;
    logic we;
    logic [3:0] ack;
    logic [1:0] gid;
  } vec_t;
  typedef struct {
    logic we;
    logic [3:0] ack;
    logic [1:0] gid;
    logic [2:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  vec_t tab[17];
  logic [2:0] addr_tab[4] = '{3'd1, 3'd3, 3'd5, 3'd7};
  logic [15:0] data_tab[4] = '{16'h1111, 16'h2222, 16'hBEEF, 16'h4444};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic check4(input string tag, input logic we, input logic [3:0] ack, input logic [1:0] gid,
                        input logic [2:0] addr, input logic [15:0] data);
    chk({tag, ".we"}, 32'(b4.write_enabled), 32'(we));
    chk({tag, ".ack"}, 32'(b4.ack), 32'(ack));
    chk({tag, ".gid"}, 32'(b4.grant_id), 32'(gid));
    chk({tag, ".addr"}, 32'(b4.write_addr), 32'(addr));
    chk({tag, ".data"}, 32'(b4.write_data), 32'(data));
  endtask
  task automatic check3(input string tag, input logic we, input logic [2:0] ack, input logic [1:0] gid,
                        input logic [2:0] addr, input logic [15:0] data);
    chk({tag, ".we"}, 32'(b3.write_enabled), 32'(we));
    chk({tag, ".ack"}, 32'(b3.ack), 32'(ack));
    chk({tag, ".gid"}, 32'(b3.grant_id), 32'(gid));
    chk({tag, ".addr"}, 32'(b3.write_addr), 32'(addr));
    chk({tag, ".data"}, 32'(b3.write_data), 32'(data));
  endtask
  task automatic step(input int i);
    exp_t e;
    b4.req = tab[i].req;
    b4.stall = tab[i].stall;
    e = '{tab[i].we, tab[i].ack, tab[i].gid, addr_tab[tab[i].gid], data_tab[tab[i].gid]};
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check4($sformatf("vec%0d", i), e.we, e.ack, e.gid, e.addr, e.data);
  endtask
  initial begin
    tab[0] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0};
    tab[1] = '{4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
    tab[2] = '{4'b1101, 1'b0, 1'b1, 4'b0100, 2'd2};
    tab[3] = '{4'b1011, 1'b0, 1'b1, 4'b1000, 2'd3};
    tab[4] = '{4'b0111, 1'b0, 1'b1, 4'b0001, 2'd0};
    tab[5] = '{4'b1110, 1'b0, 1'b1, 4'b0010, 2'd1};
    tab[6] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2};
    tab[7] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd2};
    tab[8] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2};
    tab[9] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd2};
    tab[10] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3};
    tab[11] = '{4'b0110, 1'b1, 1'b0, 4'b0000, 2'd3};
    tab[12] = '{4'b0110, 1'b1, 1'b0, 4'b0000, 2'd3};
    tab[13] = '{4'b0110, 1'b1, 1'b0, 4'b0000, 2'd3};
    tab[14] = '{4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1};
    tab[15] = '{4'b0110, 1'b0, 1'b1, 4'b0100, 2'd2};
    tab[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2};
    b4.req = 4'b1111;
    b4.stall = 1'b0;
    b4.req_addr = {3'd7, 3'd5, 3'd3, 3'd1};
    b4.req_data = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    b3.req = 3'b000;
    b3.stall = 1'b0;
    b3.req_addr = {3'd5, 3'd3, 3'd1};
    b3.req_data = {16'hBEEF, 16'h2222, 16'h1111};
    repeat (2) @(negedge clk);
    check4("reset", 1'b0, 4'b0000, 2'd0, 3'd0, 16'h0);
    check3("reset3", 1'b0, 3'b000, 2'd0, 3'd0, 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step(i);
    b4.req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check4("pre_rst", 1'b1, 4'b1000, 2'd3, 3'd7, 16'h4444);
    #2 reset = 1'b1;
    #1 check4("async_rst", 1'b0, 4'b0000, 2'd0, 3'd0, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check4("post_rst", 1'b1, 4'b1000, 2'd3, 3'd7, 16'h4444);
    b4.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check4("post_rst_idle", 1'b0, 4'b0000, 2'd3, 3'd7, 16'h4444);
    end
    b3.req = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check3("w3_g1", 1'b1, 3'b010, 2'd1, 3'd3, 16'h2222);
    b3.req = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check3("w3_idle", 1'b0, 3'b000, 2'd1, 3'd3, 16'h2222);
    b3.req = 3'b011;
    @(posedge clk);
    @(negedge clk);
    check3("w3_wrap", 1'b1, 3'b001, 2'd0, 3'd1, 16'h1111);
    b3.req = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check3("w3_next", 1'b1, 3'b010, 2'd1, 3'd3, 16'h2222);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
